// File: rtl/painterengine_gpu_stream_buffer_pkg.sv
// Shared definitions for the GPU stream buffer.
// FSM state codes used by the top level and its bench.
package painterengine_gpu_stream_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERROR = 2'b11
  } sb_state_t;

  localparam int unsigned SB_LEN_W = 32;

endpackage

// File: rtl/painterengine_gpu_stream_buffer_sync_fifo.sv
// Synchronous FIFO: inferred dual-port RAM plus registered FWFT head.
// Ports: push/data_i in, pop/data_o/valid_o out, flush, level/full/empty.
module painterengine_gpu_sync_fifo
  import painterengine_gpu_stream_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [DEPTH_LOG2:0] level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   ram_cnt_q, ram_cnt_d;
  logic [DATA_W-1:0]     head_q, head_d;
  logic                  hvld_q, hvld_d;
  logic                  load;

  // Refill the head whenever it is free or leaving this cycle.
  assign load = (ram_cnt_q != '0) & (~hvld_q | pop_i);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    head_d    = head_q;
    hvld_d    = hvld_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      hvld_d    = 1'b0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) begin
        head_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + 1'b1;
        hvld_d   = 1'b1;
      end else if (pop_i) begin
        hvld_d = 1'b0;
      end
      ram_cnt_d = ram_cnt_q
                + {{DEPTH_LOG2{1'b0}}, push_i}
                - {{DEPTH_LOG2{1'b0}}, load};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      head_q    <= '0;
      hvld_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      head_q    <= head_d;
      hvld_q    <= hvld_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = hvld_q;
  assign level_o = ram_cnt_q
                 + {{DEPTH_LOG2{1'b0}}, hvld_q};
  assign full_o  = (level_o == FULL_LVL);
  // No word is presented at the head.
  assign empty_o = ~hvld_q;

endmodule

// File: rtl/painterengine_gpu_stream_buffer.sv
// Elastic buffer after one DMA reader channel; counts words, flags done/error.
// Ports: reader in (data/valid/next), consumer out, start/length, status.
module painterengine_gpu_stream_buffer
  import painterengine_gpu_stream_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  i_wire_clock,
  input  logic                  i_wire_resetn,
  input  logic                  i_wire_start,
  input  logic [31:0]           i_wire_length,
  input  logic                  i_wire_upstream_error,
  input  logic [DATA_W-1:0]     i_wire_data,
  input  logic                  i_wire_data_valid,
  output logic                  o_wire_data_next,
  output logic [DATA_W-1:0]     o_wire_data,
  output logic                  o_wire_data_valid,
  input  logic                  i_wire_data_next,
  output logic [DEPTH_LOG2:0]   o_wire_level,
  output logic                  o_wire_busy,
  output logic                  o_wire_done,
  output logic                  o_wire_error
);

  sb_state_t             state_q, state_d;
  logic [SB_LEN_W-1:0]   len_q, in_cnt_q, out_cnt_q;
  logic                  start_ok, push, pop, last;
  logic                  flush, fifo_full, fifo_empty;

  assign start_ok = i_wire_start & (state_q != ST_RUN);
  assign push     = i_wire_data_valid & o_wire_data_next;
  assign pop      = o_wire_data_valid & i_wire_data_next;
  assign last     = (out_cnt_q + SB_LEN_W'(pop)) == len_q;

  // Ready depends on registered state only, never on either valid.
  assign o_wire_data_next = (state_q == ST_RUN)
                          & (in_cnt_q < len_q)
                          & ~fifo_full;

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (last) begin
          state_d = ST_DONE;
        end else if (i_wire_upstream_error) begin
          state_d = ST_ERROR;
          flush   = 1'b1;
        end
      end
      default: begin
        if (i_wire_start) begin
          flush   = 1'b1;
          state_d = (i_wire_length == '0) ? ST_ERROR
                                          : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q     <= i_wire_length;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        in_cnt_q  <= in_cnt_q + SB_LEN_W'(push);
        out_cnt_q <= out_cnt_q + SB_LEN_W'(pop);
      end
    end
  end

  painterengine_gpu_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk_i   (i_wire_clock),
    .rst_ni  (i_wire_resetn),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (i_wire_data),
    .pop_i   (pop),
    .data_o  (o_wire_data),
    .valid_o (o_wire_data_valid),
    .level_o (o_wire_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_wire_busy  = (state_q == ST_RUN);
  assign o_wire_done  = (state_q == ST_DONE);
  // Outside RUN the head is always drained or flushed.
  assign o_wire_error = (state_q == ST_ERROR)
                      & fifo_empty;

endmodule

// File: tb/tb_painterengine_gpu_stream_buffer.sv
// Randomized bench for the GPU stream buffer.
// Checks every cycle against a queue-based behavioural model.
module tb_painterengine_gpu_stream_buffer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] len = '0;
  logic        uerr = 1'b0;
  logic [31:0] in_d = '0;
  logic        in_v = 1'b0;
  logic        in_rdy;
  logic [31:0] out_d;
  logic        out_v;
  logic        out_rdy = 1'b0;
  logic [4:0]  level;
  logic        busy, done, err;

  painterengine_gpu_stream_buffer dut (
    .i_wire_clock          (clk),
    .i_wire_resetn         (rstn),
    .i_wire_start          (start),
    .i_wire_length         (len),
    .i_wire_upstream_error (uerr),
    .i_wire_data           (in_d),
    .i_wire_data_valid     (in_v),
    .o_wire_data_next      (in_rdy),
    .o_wire_data           (out_d),
    .o_wire_data_valid     (out_v),
    .i_wire_data_next      (out_rdy),
    .o_wire_level          (level),
    .o_wire_busy           (busy),
    .o_wire_done           (done),
    .o_wire_error          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: 0 idle, 1 run, 2 done, 3 error.
  typedef struct { logic [31:0] w; int t; } ent_t;
  ent_t        q[$];
  int          cyc = 0;
  int          m_st = 0;
  logic [31:0] m_len = '0, m_in = '0, m_out = '0;
  int          dut_pops = 0;
  bit          seq = 1'b0;
  logic [31:0] base = '0;

  function automatic bit m_valid();
    return q.size() > 0 && cyc >= q[0].t + 1;
  endfunction

  task automatic drive(int pv, int pr);
    in_v    = ($urandom % 100) < pv;
    out_rdy = ($urandom % 100) < pr;
    in_d    = seq ? base + m_in : $urandom;
  endtask

  task automatic tick();
    bit e_next, e_val, push, pop;
    ent_t e;
    @(negedge clk);
    e_next = (m_st == 1) && (m_in < m_len)
             && (q.size() < 16);
    e_val  = m_valid();
    chk("next",  32'(in_rdy), 32'(e_next));
    chk("valid", 32'(out_v),  32'(e_val));
    chk("level", 32'(level),  32'(q.size()));
    chk("busy",  32'(busy),   32'(m_st == 1));
    chk("done",  32'(done),   32'(m_st == 2));
    chk("error", 32'(err),    32'(m_st == 3));
    if (e_val) chk("data", out_d, q[0].w);
    if (out_v && out_rdy) dut_pops++;
    push = in_v && e_next;
    pop  = out_rdy && e_val;
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(q.pop_front());
      m_out++;
    end
    if (push) begin
      e.w = in_d;
      e.t = cyc;
      q.push_back(e);
      m_in++;
    end
    if (start && m_st != 1) begin
      q.delete();
      m_in = '0;
      m_out = '0;
      m_len = len;
      m_st = (len == 0) ? 3 : 1;
    end else if (m_st == 1) begin
      if (pop && m_out == m_len) m_st = 2;
      else if (uerr) begin
        m_st = 3;
        q.delete();
      end
    end
    #1;
  endtask

  task automatic kick(logic [31:0] l);
    in_v = 1'b0;
    out_rdy = 1'b0;
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic run(int n, int pv, int pr);
    for (int i = 0; i < n; i++) begin
      drive(pv, pr);
      tick();
    end
  endtask

  task automatic all_zero(string tag);
    chk({tag, "_next"},  32'(in_rdy), 0);
    chk({tag, "_valid"}, 32'(out_v),  0);
    chk({tag, "_data"},  out_d,       0);
    chk({tag, "_level"}, 32'(level),  0);
    chk({tag, "_busy"},  32'(busy),   0);
    chk({tag, "_done"},  32'(done),   0);
    chk({tag, "_err"},   32'(err),    0);
  endtask

  initial begin
    int n;
    void'($urandom(32'h5eed_1234));
    #2;
    all_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    run(2, 100, 100);

    // 1: len=4 sequential words, consumer always ready
    seq = 1'b1;
    base = 32'hA0;
    kick(4);
    run(12, 100, 100);
    chk("t1_done", 32'(done), 1);

    // 2: len=20 with stalled consumer fills 16
    base = 32'h200;
    kick(20);
    run(30, 100, 0);
    chk("t2_level", 32'(level), 16);
    chk("t2_next", 32'(in_rdy), 0);
    run(40, 100, 100);
    chk("t2_done", 32'(done), 1);

    // 3: zero length
    kick(0);
    chk("t3_err", 32'(err), 1);
    run(5, 100, 100);
    chk("t3_busy", 32'(busy), 0);

    // 4: upstream error after 3 words, then restart
    base = 32'h300;
    kick(8);
    n = 0;
    while (m_in < 3 && n < 20) begin
      drive(100, 0);
      tick();
      n++;
    end
    chk("t4_accepts", m_in, 3);
    in_v = 1'b0;
    uerr = 1'b1;
    tick();
    uerr = 1'b0;
    tick();
    chk("t4_err", 32'(err), 1);
    chk("t4_level", 32'(level), 0);
    kick(2);
    run(8, 100, 100);
    chk("t4_done", 32'(done), 1);

    // 5: random handshakes, len=1000
    seq = 1'b0;
    kick(1000);
    dut_pops = 0;
    n = 0;
    while (m_st == 1 && n < 20000) begin
      drive(60, 55);
      tick();
      n++;
    end
    chk("t5_done", 32'(done), 1);
    chk("t5_pops", dut_pops, 1000);

    // 6: async reset mid-run with level 5
    kick(10);
    n = 0;
    while (q.size() < 5 && n < 20) begin
      drive(100, 0);
      tick();
      n++;
    end
    chk("t6_level", 32'(level), 5);
    in_v = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    all_zero("t6");
    q.delete();
    m_st = 0;
    m_in = '0;
    m_out = '0;
    m_len = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run(4, 100, 100);
    chk("t6_idle_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
